// File: rtl/load_store_unit_if.sv
// Request, data-memory and writeback signal bundle for load_store_unit.
// The slave modport is the LSU; the master modport is its environment.
interface load_store_unit_if #(parameter int unsigned XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic            is_store;
  logic [2:0]      mem_op;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] store_data;
  logic [4:0]      rd_in;
  logic            flush;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            busy;
  logic            misalign_exc;
  logic [XLEN-1:0] misalign_addr;

  modport slave (
    input  req_valid, is_store, mem_op, addr, store_data, rd_in, flush,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    output req_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output wb_valid, wb_rd, wb_data, busy, misalign_exc, misalign_addr
  );

  modport master (
    output req_valid, is_store, mem_op, addr, store_data, rd_in, flush,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    input  req_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  wb_valid, wb_rd, wb_data, busy, misalign_exc, misalign_addr
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between EX/MEM and a req/gnt/rvalid data memory.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them down.
module load_store_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic         clk,
    input logic         reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] store_data_q, store_data_d;
    logic [2:0]      mem_op_q, mem_op_d;
    logic            is_store_q, is_store_d;
    logic [4:0]      rd_q, rd_d;
    logic            flushed_q, flushed_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic            accept;
    logic [1:0]      off;
    logic [3:0]      be_raw;
    logic [15:0]     rsel;
    logic [XLEN-1:0] load_ext;

`ifdef MISALIGN_TRAP_EN
    logic            misalign_exc_q, misalign_exc_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
    logic            misaligned_in;

    assign misaligned_in = (bus.mem_op[1:0] == 2'b01 && bus.addr[0]) ||
                           (bus.mem_op[1] && bus.addr[1:0] != 2'b00);
    assign bus.misalign_exc  = misalign_exc_q;
    assign bus.misalign_addr = misalign_addr_q;
`else
    assign bus.misalign_exc  = 1'b0;
    assign bus.misalign_addr = '0;
`endif

    // flush in IDLE blocks acceptance for that cycle
    assign accept = bus.req_valid && (state_q == IDLE) && !bus.flush;

    always_comb begin
        off = addr_q[1:0];
`ifdef MISALIGN_TRAP_EN
        off = addr_q[1:0];
`else
        // misaligned halves/words are silently aligned down
        if (mem_op_q[1:0] == 2'b01)
            off = {addr_q[1], 1'b0};
        else if (mem_op_q[1])
            off = 2'b00;
`endif
    end

    always_comb begin
        be_raw         = 4'b1111;
        bus.dmem_wdata = store_data_q;
        case (mem_op_q[1:0])
            2'b00: begin
                be_raw         = 4'b0001 << off;
                bus.dmem_wdata = {4{store_data_q[7:0]}};
            end
            2'b01: begin
                be_raw         = 4'b0011 << off;
                bus.dmem_wdata = {2{store_data_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign rsel = 16'(bus.dmem_rdata >> {off, 3'b000});

    always_comb begin
        case (mem_op_q[1:0])
            2'b00:   load_ext = {{(XLEN-8){rsel[7] & ~mem_op_q[2]}}, rsel[7:0]};
            2'b01:   load_ext = {{(XLEN-16){rsel[15] & ~mem_op_q[2]}}, rsel[15:0]};
            default: load_ext = bus.dmem_rdata;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.dmem_req  = (state_q == REQ);
    assign bus.dmem_we   = (state_q == REQ) && is_store_q;
    assign bus.dmem_be   = (state_q == REQ) ? be_raw : 4'b0000;
    assign bus.dmem_addr = {addr_q[XLEN-1:2], 2'b00};
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        store_data_d = store_data_q;
        mem_op_d     = mem_op_q;
        is_store_d   = is_store_q;
        rd_d         = rd_q;
        flushed_d    = flushed_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
`ifdef MISALIGN_TRAP_EN
        misalign_exc_d  = 1'b0;
        misalign_addr_d = misalign_addr_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d       = bus.addr;
                    store_data_d = bus.store_data;
                    mem_op_d     = bus.mem_op;
                    is_store_d   = bus.is_store;
                    rd_d         = bus.rd_in;
                    flushed_d    = 1'b0;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned_in) begin
                        misalign_exc_d  = 1'b1;
                        misalign_addr_d = bus.addr;
                    end else begin
                        state_d = REQ;
                    end
`else
                    state_d = REQ;
`endif
                end
            end
            REQ: begin
                // once granted the access must finish; a flush only hides its result
                if (bus.dmem_gnt) begin
                    flushed_d = bus.flush;
                    state_d   = is_store_q ? IDLE : WAIT_R;
                end else if (bus.flush) begin
                    state_d = IDLE;
                end
            end
            WAIT_R: begin
                if (bus.flush)
                    flushed_d = 1'b1;
                if (bus.dmem_rvalid) begin
                    state_d = IDLE;
                    if (!flushed_q && !bus.flush) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = load_ext;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            store_data_q <= '0;
            mem_op_q     <= '0;
            is_store_q   <= 1'b0;
            rd_q         <= '0;
            flushed_q    <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            store_data_q <= store_data_d;
            mem_op_q     <= mem_op_d;
            is_store_q   <= is_store_d;
            rd_q         <= rd_d;
            flushed_q    <= flushed_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_exc_q  <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_exc_q  <= misalign_exc_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end
`endif
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width; only 32 is supported.
REQ-002 SHALL use one clock; reset is synchronous and active-high. Ports: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-003 SHALL have these request ports:
- req_valid  input  1  EX/MEM holds a memory op
- req_ready  output  1  unit can accept
- is_store  input  1  1 = store, 0 = load
- mem_op  input  3  func3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  32  effective address (ALU result)
- store_data  input  32  rs2 value
- rd_in  input  5  load destination register
- flush  input  1  abort the op in flight
REQ-004 SHALL have these data-memory ports:
- dmem_req  output  1  request
- dmem_we  output  1  write enable
- dmem_addr  output  32  {addr[31:2],2'b00}
- dmem_be  output  4  byte enables
- dmem_wdata  output  32  write data
- dmem_gnt  input  1  request accepted
- dmem_rvalid  input  1  read data valid
- dmem_rdata  input  32  read word
REQ-005 SHALL have these writeback ports:
- wb_valid  output  1  one-cycle load result
- wb_rd  output  5  destination register
- wb_data  output  32  extended load data
- busy  output  1  stall to pipeline
- misalign_exc  output  1  one-cycle trap pulse
- misalign_addr  output  32  faulting address

Function
REQ-006 SHALL implement FSM states IDLE, REQ, WAIT_R; req_ready = (state==IDLE); busy = !req_ready.
REQ-007 SHALL register addr, mem_op, is_store, store_data and rd_in on accept (req_valid & req_ready), and move IDLE->REQ.
REQ-008 In REQ, dmem_req SHALL be held high with stable addr/we/be/wdata until dmem_gnt; with is_store the unit SHALL go REQ->IDLE on grant, otherwise REQ->WAIT_R.
REQ-009 In WAIT_R, on dmem_rvalid the unit SHALL pulse wb_valid for exactly 1 cycle, with wb_rd and wb_data, and go to IDLE; dmem_rvalid is never asserted in the grant cycle.
REQ-010 SHALL derive off = addr[1:0] and byte enables as follows:
- B: dmem_be = 4'b0001<<off
- H: dmem_be = 4'b0011<<off
- W: dmem_be = 4'b1111
- dmem_wdata = {4{sd[7:0]}} for B, {2{sd[15:0]}} for H, sd for W.
REQ-011 Loads SHALL select byte/half dmem_rdata[8*off +: 8/16]; B/H sign-extend, BU/HU zero-extend, W pass through.
REQ-012 flush in REQ before grant SHALL return the unit to IDLE with dmem_req low next cycle; flush in the grant cycle or WAIT_R SHALL let the access complete but suppress wb_valid.
REQ-013 flush in IDLE SHALL block acceptance that cycle; a new request SHALL never be accepted while busy.
REQ-014 Load latency SHALL be accept->dmem_req 1 cycle; minimum accept->wb_valid 3 cycles (gnt immediate, rvalid next cycle).

Reset
REQ-015 reset SHALL force state IDLE, and drive req_ready=1, busy=0, dmem_req=0, dmem_we=0, dmem_be=0, wb_valid=0 and misalign_exc=0; wb_data, wb_rd, dmem_addr, dmem_wdata and misalign_addr SHALL be 0.
REQ-016 reset asserted mid-operation SHALL drop dmem_req the next cycle and never emit wb_valid for the aborted op.

Configuration
REQ-017 Macro MISALIGN_TRAP_EN SHALL control misalignment handling; a misaligned op is H with addr[0]=1, or W with addr[1:0]!=0.
- Defined: a misaligned op is accepted but issues no dmem_req; misalign_exc pulses 1 cycle after accept with misalign_addr=addr, and the unit returns to IDLE.
- Undefined: off is forced to {addr[1],1'b0} for H and 2'b00 for W; misalign_exc and misalign_addr are tied 0.

Verification
REQ-018 SW addr 0x1000, data 0xDEADBEEF, gnt immediate -> dmem_req 1 cycle, be=1111, wdata=0xDEADBEEF, we=1, no wb_valid.
REQ-019 LB addr 0x2003, rdata 0x80FF_0000 -> wb_data=0xFFFFFF80; LBU same stimulus -> 0x00000080; LHU addr 0x2002 -> 0x000080FF.
REQ-020 SH addr 0x3002, data 0x1234ABCD, gnt delayed 3 cycles -> be=1100, wdata=0xABCDABCD held stable 4 cycles, req_ready low throughout.
REQ-021 LW with flush in the REQ cycle before gnt -> dmem_req drops next cycle; LW with flush in WAIT_R -> rvalid consumed, wb_valid stays 0.
REQ-022 LW addr 0x4002 -> with MISALIGN_TRAP_EN: misalign_exc=1, misalign_addr=0x4002, no dmem_req; without: dmem_addr=0x4000, be=1111.
REQ-023 reset asserted in WAIT_R -> next cycle IDLE, req_ready=1, and a later rvalid produces no wb_valid.
